// File: rtl/axis_rr_packet_arbiter.sv
// Packet-granular round-robin arbiter: NUM_INPUTS AXI-Stream sources share one
// registered master port, and the source index of each beat travels on m_axis_tid.
module axis_rr_packet_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_INPUTS = 4,
  localparam int ID_WIDTH = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_INPUTS-1:0]            s_axis_tvalid,
  input  logic [NUM_INPUTS-1:0]            s_axis_tlast,
  output logic [NUM_INPUTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic                             m_axis_tvalid,
  output logic                             m_axis_tlast,
  output logic [ID_WIDTH-1:0]              m_axis_tid,
  input  logic                             m_axis_tready
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ID_WIDTH-1:0] grant_r;
  logic [ID_WIDTH-1:0] pick_s;
  logic                stall_s;
  logic                accept_s;

  function automatic logic [ID_WIDTH-1:0] rr_pick(
    input logic [NUM_INPUTS-1:0] req,
    input logic [ID_WIDTH-1:0]   last
  );
    logic [ID_WIDTH-1:0] pick;
    logic                found;
    int                  idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      idx = (int'(last) + k) % NUM_INPUTS;
      if (!found && req[idx]) begin
        pick  = ID_WIDTH'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  assign stall_s  = m_axis_tvalid && !m_axis_tready;
  assign pick_s   = rr_pick(s_axis_tvalid, grant_r);
  assign accept_s = s_axis_tvalid[grant_r] && s_axis_tready[grant_r];

  // State register
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // grant_r doubles as last_grant; resetting it to the top index gives input 0 first turn
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      grant_r <= ID_WIDTH'(NUM_INPUTS - 1);
    end else if (state_r == IDLE && (|s_axis_tvalid)) begin
      grant_r <= pick_s;
    end else begin
      grant_r <= grant_r;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (|s_axis_tvalid) state_nxt_s = BUSY;
        else                state_nxt_s = IDLE;
      end
      BUSY: begin
        if (accept_s && s_axis_tlast[grant_r]) state_nxt_s = IDLE;
        else                                   state_nxt_s = BUSY;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Only the granted source sees ready, and only while the output register can move
  always_comb begin
    s_axis_tready = '0;
    if (aresetn && state_r == BUSY) begin
      s_axis_tready[grant_r] = !stall_s;
    end else begin
      s_axis_tready = '0;
    end
  end

  // Output register stage
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
      m_axis_tvalid <= 1'b0;
    end else begin
      if (!stall_s) begin
        m_axis_tdata <= s_axis_tdata[grant_r*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tlast <= s_axis_tlast[grant_r];
        m_axis_tid   <= grant_r;
      end else begin
        m_axis_tdata <= m_axis_tdata;
        m_axis_tlast <= m_axis_tlast;
        m_axis_tid   <= m_axis_tid;
      end
      m_axis_tvalid <= stall_s || (state_r == BUSY && s_axis_tvalid[grant_r]);
    end
  end

endmodule
